// File: rtl/ibex_pin_bridge_pkg.sv
// Shared types and sizing helpers for the Ibex pin-limited memory bridge.
package ibex_pin_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ADDR,
      ST_WDATA,
      ST_STAT,
      ST_RDATA,
      ST_DONE
   } state_e;

   // Header beat layout, sent zero-extended in pad_out_o[5:0]
   typedef struct packed {
      logic       ch;
      logic       we;
      logic [3:0] be;
   } hdr_t;

   localparam logic CH_INSTR = 1'b0;
   localparam logic CH_DATA  = 1'b1;

   function automatic int beats_per_word(input int pin_w);
      return 32 / pin_w;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ibex_pin_bridge_arb.sv
// Two-way arbiter between the instr and data ports: fixed data priority or round-robin.
module ibex_pin_bridge_arb #(
   parameter int ARB_RR = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic instr_req_i,
   input  logic data_req_i,
   output logic instr_gnt_o,
   output logic data_gnt_o
);

   // Set when the data port won last; reset value makes instr the favoured port
   logic last_data_q;
   logic pick_data;

   always_comb begin
      pick_data = data_req_i;
      if (instr_req_i && data_req_i) begin
         pick_data = (ARB_RR != 0) ? !last_data_q : 1'b1;
      end
   end

   assign data_gnt_o  = en_i && data_req_i && pick_data;
   assign instr_gnt_o = en_i && instr_req_i && !pick_data;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_data_q <= 1'b1;
      end else if (instr_gnt_o || data_gnt_o) begin
         last_data_q <= data_gnt_o;
      end
   end

endmodule

// File: rtl/ibex_pin_bridge.sv
// Bridges the Ibex instr/data ports onto a narrow serial pad link, one transaction at a time.
module ibex_pin_bridge
   import ibex_pin_bridge_pkg::*;
#(
   parameter int PIN_W       = 8,
   parameter int ARB_RR      = 0,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             instr_req_i,
   output logic             instr_gnt_o,
   output logic             instr_rvalid_o,
   input  logic [31:0]      instr_addr_i,
   output logic [31:0]      instr_rdata_o,
   output logic             instr_err_o,
   input  logic             data_req_i,
   output logic             data_gnt_o,
   output logic             data_rvalid_o,
   input  logic             data_we_i,
   input  logic [3:0]       data_be_i,
   input  logic [31:0]      data_addr_i,
   input  logic [31:0]      data_wdata_i,
   output logic [31:0]      data_rdata_o,
   output logic             data_err_o,
   output logic [PIN_W-1:0] pad_out_o,
   output logic             pad_out_valid_o,
   input  logic             pad_out_ready_i,
   input  logic [PIN_W-1:0] pad_in_i,
   input  logic             pad_in_valid_i
);

   localparam int NB = beats_per_word(PIN_W);
   localparam int BW = cnt_width(NB);
   localparam int TW = cnt_width(TIMEOUT_CYC);
   localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);

   state_e         state_q;
   hdr_t           hdr_q;
   logic [63:0]    sh_q;      // {wdata, addr}, shifted out LSB-first
   logic [BW-1:0]  beat_q;
   logic [TW-1:0]  tmo_q;
   logic [31:0]    acc_q;
   logic           serr_q;
   logic [31:0]    instr_rdata_q, data_rdata_q;
   logic           instr_err_q, data_err_q, instr_rvalid_q, data_rvalid_q;

   logic           out_fire, fin, fin_err;
   logic [31:0]    fin_rdata, acc_nxt;

   ibex_pin_bridge_arb #(.ARB_RR(ARB_RR)) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        ((state_q == ST_IDLE) && !rst_i),
      .instr_req_i (instr_req_i),
      .data_req_i  (data_req_i),
      .instr_gnt_o (instr_gnt_o),
      .data_gnt_o  (data_gnt_o)
   );

   // Outbound link: a beat transfers on any cycle where pad_out_valid_o && pad_out_ready_i;
   // valid is held with stable data until accepted. Inbound beats have no backpressure.
   assign pad_out_valid_o = (state_q == ST_HDR) || (state_q == ST_ADDR) || (state_q == ST_WDATA);
   assign pad_out_o       = !pad_out_valid_o ? '0 :
                            (state_q == ST_HDR) ? PIN_W'(hdr_q) : sh_q[PIN_W-1:0];
   assign out_fire        = pad_out_valid_o && pad_out_ready_i;

   always_comb begin
      acc_nxt   = acc_q;
      fin       = 1'b0;
      fin_err   = 1'b0;
      fin_rdata = '0;
      for (int k = 0; k < NB; k++) begin
         if (beat_q == BW'(k)) acc_nxt[k*PIN_W +: PIN_W] = pad_in_i;
      end
      if (state_q == ST_STAT) begin
         if (pad_in_valid_i && hdr_q.we) begin
            fin     = 1'b1;
            fin_err = pad_in_i[0];
         end else if (!pad_in_valid_i && tmo_q == TMO_LAST) begin
            fin     = 1'b1;
            fin_err = 1'b1;
         end
      end else if (state_q == ST_RDATA) begin
         if (pad_in_valid_i && beat_q == LAST_BEAT) begin
            fin       = 1'b1;
            fin_err   = serr_q;
            fin_rdata = serr_q ? '0 : acc_nxt;
         end else if (!pad_in_valid_i && tmo_q == TMO_LAST) begin
            fin     = 1'b1;
            fin_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         hdr_q          <= '0;
         sh_q           <= '0;
         beat_q         <= '0;
         tmo_q          <= '0;
         acc_q          <= '0;
         serr_q         <= 1'b0;
         instr_rdata_q  <= '0;
         instr_err_q    <= 1'b0;
         instr_rvalid_q <= 1'b0;
         data_rdata_q   <= '0;
         data_err_q     <= 1'b0;
         data_rvalid_q  <= 1'b0;
      end else begin
         instr_rvalid_q <= 1'b0;
         data_rvalid_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (instr_gnt_o || data_gnt_o) begin
                  hdr_q.ch <= data_gnt_o ? CH_DATA : CH_INSTR;
                  hdr_q.we <= data_gnt_o && data_we_i;
                  hdr_q.be <= data_gnt_o ? data_be_i : 4'hF;
                  sh_q     <= data_gnt_o ? {data_wdata_i, data_addr_i} : {32'h0, instr_addr_i};
                  beat_q   <= '0;
                  state_q  <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (out_fire) state_q <= ST_ADDR;
            end
            ST_ADDR, ST_WDATA: begin
               if (out_fire) begin
                  sh_q <= sh_q >> PIN_W;
                  if (beat_q == LAST_BEAT) begin
                     beat_q <= '0;
                     tmo_q  <= '0;
                     state_q <= (state_q == ST_ADDR && hdr_q.we) ? ST_WDATA : ST_STAT;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            ST_STAT, ST_RDATA: begin
               if (pad_in_valid_i) begin
                  tmo_q <= '0;
                  if (state_q == ST_STAT) begin
                     serr_q  <= pad_in_i[0];
                     beat_q  <= '0;
                     if (!hdr_q.we) state_q <= ST_RDATA;
                  end else begin
                     acc_q  <= acc_nxt;
                     beat_q <= beat_q + 1'b1;
                  end
               end else if (tmo_q != TMO_MAX) begin
                  tmo_q <= tmo_q + 1'b1;
               end
               if (fin) begin
                  state_q <= ST_DONE;
                  if (hdr_q.ch == CH_DATA) begin
                     data_rvalid_q <= 1'b1;
                     data_rdata_q  <= fin_rdata;
                     data_err_q    <= fin_err;
                  end else begin
                     instr_rvalid_q <= 1'b1;
                     instr_rdata_q  <= fin_rdata;
                     instr_err_q    <= fin_err;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign instr_rvalid_o = instr_rvalid_q;
   assign instr_rdata_o  = instr_rdata_q;
   assign instr_err_o    = instr_err_q;
   assign data_rvalid_o  = data_rvalid_q;
   assign data_rdata_o   = data_rdata_q;
   assign data_err_o     = data_err_q;

endmodule
